// File: rtl/stimulus_gen_pkg.sv
// Shared constants for stimulus_gen: FSM encodings, LFSR taps, seed and corner constants.
package stimulus_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_TAPS   = 32'h80200003;
  localparam logic [31:0] B_SEED_XOR  = 32'hDEADBEEF;
  localparam int          CORNER_CNT  = 4;

  // Galois right-shift step.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/stimulus_gen_lfsr32.sv
// 32-bit Galois LFSR with synchronous reseed and step enable.
module lfsr32
  import stimulus_gen_pkg::*;
#(
  parameter logic [31:0] RESET_SEED = 32'h00000001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   state <= RESET_SEED;
    else if (load)  state <= seed;
    else if (step)  state <= lfsr_next(state);
  end

endmodule

// File: rtl/stimulus_gen.sv
// Operand pair generator with valid/ready output and delayed scoreboard freeze strobe.
// Optional STIMGEN_CORNER_EN prepends four all-zero/all-one corner pairs to each run.
module stimulus_gen
  import stimulus_gen_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter int          LATENCY = 1,
  parameter logic [31:0] SEED    = 32'h00000001
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [31:0]      i_count,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_freeze,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_sent_ctr,
  output logic [1:0]       o_state
);

  // Handshake: a transfer happens in any cycle where o_valid && i_ready;
  // o_a/o_b hold steady while o_valid is high and i_ready is low.

  localparam logic [31:0] SEED_B     = SEED ^ B_SEED_XOR;
  localparam logic [3:0]  DRAIN_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t      state;
  logic [31:0] count_q;
  logic [3:0]  drain_ctr;
  logic [31:0] lfsr_a, lfsr_b;
  logic [31:0] sent_next;
  logic        hs, load, step;

  assign hs        = o_valid && i_ready;
  assign load      = i_start && (state == ST_IDLE || state == ST_DONE);
  assign sent_next = o_sent_ctr + 32'd1;
  assign o_valid   = (state == ST_RUN);
  assign o_busy    = (state == ST_RUN) || (state == ST_DRAIN);
  assign o_done    = (state == ST_DONE);
  assign o_state   = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      count_q    <= '0;
      drain_ctr  <= '0;
      o_sent_ctr <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state      <= ST_RUN;
            count_q    <= i_count;
            o_sent_ctr <= '0;
          end
        end
        ST_RUN: begin
          if (hs) o_sent_ctr <= sent_next;
          // A stop coinciding with a transfer still counts that transfer.
          if ((hs && count_q != 32'd0 && sent_next == count_q) || i_stop) begin
            state     <= ST_DRAIN;
            drain_ctr <= '0;
          end
        end
        ST_DRAIN: begin
          if (drain_ctr >= DRAIN_LAST) state <= ST_DONE;
          else                         drain_ctr <= drain_ctr + 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef STIMGEN_CORNER_EN
  logic [2:0] corner_idx;
  logic       in_corner;
  logic       corner_a_max, corner_b_max;

  assign in_corner    = (state == ST_RUN) && (corner_idx < 3'(CORNER_CNT));
  assign corner_a_max = (corner_idx == 3'd1) || (corner_idx == 3'd3);
  assign corner_b_max = (corner_idx == 3'd1) || (corner_idx == 3'd2);
  assign step         = hs && !in_corner;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             corner_idx <= '0;
    else if (load)            corner_idx <= '0;
    else if (hs && in_corner) corner_idx <= corner_idx + 3'd1;
  end

  assign o_a = in_corner ? {WIDTH{corner_a_max}} : lfsr_a[WIDTH-1:0];
  assign o_b = in_corner ? {WIDTH{corner_b_max}} : lfsr_b[WIDTH-1:0];
`else
  assign step = hs;
  assign o_a  = lfsr_a[WIDTH-1:0];
  assign o_b  = lfsr_b[WIDTH-1:0];
`endif

  lfsr32 #(.RESET_SEED(SEED)) u_lfsr_a (
    .clk(clk), .reset_n(reset_n), .load(load), .seed(SEED), .step(step), .state(lfsr_a)
  );

  lfsr32 #(.RESET_SEED(SEED_B)) u_lfsr_b (
    .clk(clk), .reset_n(reset_n), .load(load), .seed(SEED_B), .step(step), .state(lfsr_b)
  );

  // Freeze line carries !handshake forward so it lines up with the DUT result.
  generate
    if (LATENCY == 0) begin : g_fz_direct
      assign o_freeze = !hs;
    end else begin : g_fz_line
      logic [LATENCY-1:0] fz_q;
      logic [LATENCY:0]   fz_next;
      assign fz_next = {fz_q, !hs};
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fz_q <= '1;
        else          fz_q <= fz_next[LATENCY-1:0];
      end
      assign o_freeze = fz_q[LATENCY-1];
    end
  endgenerate

endmodule
